// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage.
//   FS_TO_DS_BUS_W / FS_BUS_*  : layout of the IF->ID bus {adef, inst, pc}
//   RESET_PC_DEFAULT           : default first fetch address after reset
//   SRAM_SIZE_WORD / WSTRB     : constant encodings driven on the read-only SRAM port
//   tag_t                      : one in-flight request tag {stale, pc}
package if_prefetch_queue_pkg;

  localparam int unsigned FS_TO_DS_BUS_W  = 65;
  localparam int unsigned FS_BUS_PC_LSB   = 0;
  localparam int unsigned FS_BUS_INST_LSB = 32;
  localparam int unsigned FS_BUS_ADEF_BIT = 64;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  localparam logic [1:0]  SRAM_SIZE_WORD  = 2'b10;
  localparam logic [3:0]  SRAM_WSTRB_NONE = 4'b0000;

  localparam int unsigned TAG_W         = 33;
  localparam int unsigned TAG_STALE_BIT = 32;

  typedef struct packed {
    logic        stale;
    logic [31:0] pc;
  } tag_t;

  function automatic logic [FS_TO_DS_BUS_W-1:0] pack_fs_bus(input logic        adef,
                                                             input logic [31:0] inst,
                                                             input logic [31:0] pc);
    logic [FS_TO_DS_BUS_W-1:0] b;
    b                            = '0;
    b[FS_BUS_PC_LSB +: 32]       = pc;
    b[FS_BUS_INST_LSB +: 32]     = inst;
    b[FS_BUS_ADEF_BIT]           = adef;
    return b;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// SRAM-like instruction bus (req/addr_ok/data_ok) between the fetch stage and memory.
//   master : fetch side, drives req/addr and the constant write fields
//   slave  : memory side, answers with addr_ok, data_ok and rdata
interface if_prefetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, addr, wr, size, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, addr, wr, size, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush and an optional mark-all bit.
//   push/push_data : write one entry (ignored during flush)
//   pop            : retire the head entry
//   flush          : empty the FIFO
//   mark_all       : set bit MARK_BIT of every stored entry and of an entry pushed this cycle
//   full/empty     : occupancy flags; count is the number of stored entries
//   head           : oldest entry
// Pointers carry one extra wrap bit so a full FIFO is distinguished from an empty one.
module if_sync_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MARK_BIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   mark_all,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] MARK_MASK = WIDTH'(1) << MARK_BIT;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] wdata;

  function automatic logic [IW-1:0] slot(input logic [PW-1:0] ptr);
    return (DEPTH > 1) ? ptr[IW-1:0] : '0;
  endfunction

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[slot(rd_ptr_q)];
  assign wdata = mark_all ? (push_data | MARK_MASK) : push_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (mark_all) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_q[i] | MARK_MASK;
      end
      // Later assignment wins, so a pushed entry gets its own (already marked) data.
      if (push && !flush) mem_q[slot(wr_ptr_q)] <= wdata;
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Pipelined instruction-fetch stage with a prefetch buffer.
//   clk, reset            : clock, synchronous active-high reset
//   redirect_valid/_pc    : flush everything and restart fetching at redirect_pc
//   fetch_stall           : block new requests only
//   inst_sram (master)    : SRAM-like req/addr_ok/data_ok instruction bus
//   ds_allow_in           : ID accepts the buffer head
//   fs_to_ds_valid/_bus   : buffer head, bus = {adef, inst, pc}
// Up to MAX_OUTSTANDING requests are in flight, each tagged with its pc in a tag FIFO.
// A redirect marks every tag stale instead of counting late responses, so any number
// of old data_ok beats is simply dropped when its stale tag reaches the head.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BUF_DEPTH       = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      fetch_stall,
  if_prefetch_queue_if.master       inst_sram,
  input  logic                      ds_allow_in,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus
);

  localparam int unsigned TW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned BW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]  pc_q, pc_d;
  logic         adef_hold_q, adef_hold_d;
  logic [TW-1:0] live_q, live_d;   // non-stale requests in flight

  logic          tag_push, tag_pop, tag_full, tag_empty;
  logic [TW-1:0] tag_count;
  logic [TAG_W-1:0] tag_head_raw;
  tag_t          tag_head;

  logic          buf_push, buf_pop, buf_full, buf_empty;
  logic [BW-1:0] buf_count;
  logic [FS_TO_DS_BUS_W-1:0] buf_push_data, buf_head;

  logic req, pc_aligned, occupancy_ok, live_pop, rsp_keep, adef_push;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  // Buffer slots are reserved for every live request so a response never finds it full.
  assign occupancy_ok = (32'(buf_count) + 32'(live_q)) < BUF_DEPTH;

  assign req = ~reset & ~redirect_valid & ~fetch_stall & ~adef_hold_q & pc_aligned
             & (32'(tag_count) < MAX_OUTSTANDING) & occupancy_ok;

  assign inst_sram.req   = req;
  assign inst_sram.addr  = pc_q;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = SRAM_SIZE_WORD;
  assign inst_sram.wstrb = SRAM_WSTRB_NONE;
  assign inst_sram.wdata = '0;

  assign tag_push = req & inst_sram.addr_ok;
  assign tag_pop  = inst_sram.data_ok & ~tag_empty;
  assign tag_head = tag_t'(tag_head_raw);
  assign live_pop = tag_pop & ~tag_head.stale;
  assign rsp_keep = live_pop & ~redirect_valid;

  // Misaligned pc: wait for live responses to drain, then deliver one adef entry.
  assign adef_push = ~redirect_valid & ~pc_aligned & ~adef_hold_q & (live_q == '0) & ~buf_full;

  assign buf_push      = rsp_keep | adef_push;
  assign buf_push_data = adef_push ? pack_fs_bus(1'b1, '0, pc_q)
                                   : pack_fs_bus(1'b0, inst_sram.rdata, tag_head.pc);
  assign buf_pop       = ~buf_empty & ds_allow_in;

  assign fs_to_ds_valid = ~buf_empty;
  assign fs_to_ds_bus   = buf_head;

  if_sync_fifo #(
    .WIDTH    (TAG_W),
    .DEPTH    (MAX_OUTSTANDING),
    .MARK_BIT (TAG_STALE_BIT)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data ({1'b0, pc_q}),
    .pop       (tag_pop),
    .flush     (1'b0),
    .mark_all  (redirect_valid),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count),
    .head      (tag_head_raw)
  );

  if_sync_fifo #(
    .WIDTH    (FS_TO_DS_BUS_W),
    .DEPTH    (BUF_DEPTH),
    .MARK_BIT (0)
  ) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .mark_all  (1'b0),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count),
    .head      (buf_head)
  );

  always_comb begin
    pc_d        = pc_q;
    adef_hold_d = adef_hold_q;
    live_d      = live_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      adef_hold_d = 1'b0;
      live_d      = '0;
    end else begin
      if (tag_push)  pc_d        = pc_q + 32'd4;
      if (adef_push) adef_hold_d = 1'b1;
      live_d = live_q + TW'(tag_push) - TW'(live_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      adef_hold_q <= 1'b0;
      live_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      adef_hold_q <= adef_hold_d;
      live_q      <= live_d;
    end
  end

  a_data_ok_has_tag: assert property (@(posedge clk) disable iff (reset)
    !(inst_sram.data_ok && tag_empty));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(tag_push && tag_full));
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int unsigned MAXO = 2;
  localparam int unsigned BUFD = 4;
  localparam logic [31:0] RPC  = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_prefetch_queue_if sram();

  if_prefetch_queue #(
    .MAX_OUTSTANDING (MAXO),
    .BUF_DEPTH       (BUFD),
    .RESET_PC        (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_stall    (fetch_stall),
    .inst_sram      (sram),
    .ds_allow_in    (ds_allow_in),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    int unsigned acc;
    bit          stale;
  } pend_t;

  pend_t       pending[$];     // SRAM side: accepted, not yet answered
  logic [64:0] exp_q[$];       // scoreboard: what ID must see, in order
  logic [31:0] exp_pc;
  bit          m_adef_hold;
  int unsigned cyc;
  int unsigned n_checks, n_fail;

  bit          k_aok, k_rsp_en, k_allow, k_stall, k_redir;
  logic [31:0] k_redir_pc;
  int unsigned k_lat;

  logic        last_req;
  logic [31:0] last_addr;
  bit          last_dok;
  int unsigned n_acc;
  logic [31:0] acc_addr[$];
  logic [31:0] dlv_pc[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0FF0;
  endfunction

  function automatic bit dok_now();
    return (pending.size() != 0) && k_rsp_en && (cyc >= pending[0].acc + k_lat);
  endfunction

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, advance the model.
  task automatic step();
    bit          dok, exp_req;
    int unsigned live, qn0;
    pend_t       h;
    logic [64:0] e;
    dok = dok_now();
    sram.data_ok   = dok;
    sram.rdata     = dok ? inst_of(pending[0].addr) : 32'hDEAD_BEEF;
    sram.addr_ok   = k_aok;
    ds_allow_in    = k_allow;
    fetch_stall    = k_stall;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    #1;
    live = 0;
    foreach (pending[i]) if (!pending[i].stale) live++;
    qn0 = exp_q.size();
    exp_req = !k_redir && !k_stall && !m_adef_hold && (exp_pc[1:0] == 2'b00)
              && (pending.size() < MAXO) && ((qn0 + live) < BUFD);
    check_eq("req", sram.req, exp_req);
    check_eq("valid", fs_to_ds_valid, qn0 != 0);
    last_req  = sram.req;
    last_addr = sram.addr;
    last_dok  = dok;
    if (fs_to_ds_valid && k_allow && qn0 != 0) begin
      e = exp_q.pop_front();
      check_eq("bus", fs_to_ds_bus, e);
      dlv_pc.push_back(fs_to_ds_bus[31:0]);
    end
    if (sram.req && k_aok) begin
      n_acc++;
      acc_addr.push_back(sram.addr);
      check_eq("addr", sram.addr, exp_pc);
      pending.push_back('{pc: exp_pc, addr: sram.addr, acc: cyc, stale: 1'b0});
    end
    if (exp_req && k_aok) exp_pc = exp_pc + 32'd4;
    if (dok) begin
      h = pending.pop_front();
      if (!h.stale && !k_redir) exp_q.push_back({1'b0, inst_of(h.pc), h.pc});
    end
    if (!k_redir && exp_pc[1:0] != 2'b00 && !m_adef_hold && live == 0 && qn0 < BUFD) begin
      exp_q.push_back({1'b1, 32'h0, exp_pc});
      m_adef_hold = 1'b1;
    end
    if (k_redir) begin
      exp_q.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      exp_pc      = k_redir_pc;
      m_adef_hold = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    sram.addr_ok   = 1'b0;
    sram.data_ok   = 1'b0;
    sram.rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_stall    = 1'b0;
    ds_allow_in    = 1'b0;
    k_aok = 1'b1; k_rsp_en = 1'b1; k_lat = 1; k_allow = 1'b1; k_stall = 1'b0;
    k_redir = 1'b0; k_redir_pc = '0;
    #1;
    check_eq("rst_req", sram.req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pending.delete();
    exp_q.delete();
    exp_pc      = RPC;
    m_adef_hold = 1'b0;
    n_acc       = 0;
    acc_addr.delete();
    dlv_pc.delete();
    #1;
    check_eq("rst_valid", fs_to_ds_valid, 1'b0);
    check_eq("rst_addr", sram.addr, RPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;

    // Back-to-back fetch, data_ok one cycle after each accept.
    do_reset();
    repeat (8) step();
    check_eq("t1_nacc", acc_addr.size() >= 3, 1'b1);
    if (acc_addr.size() >= 3) begin
      check_eq("t1_a0", acc_addr[0], 32'h1C00_0000);
      check_eq("t1_a1", acc_addr[1], 32'h1C00_0004);
      check_eq("t1_a2", acc_addr[2], 32'h1C00_0008);
    end

    // ID blocked: the buffer fills to BUF_DEPTH and req drops; then drain in order.
    do_reset();
    k_allow = 1'b0;
    repeat (10) step();
    check_eq("t2_nacc", n_acc, 4);
    check_eq("t2_req_low", last_req, 1'b0);
    check_eq("t2_valid", fs_to_ds_valid, 1'b1);
    k_aok   = 1'b0;
    k_allow = 1'b1;
    dlv_pc.delete();
    repeat (6) step();
    check_eq("t2_ndlv", dlv_pc.size(), 4);
    for (int i = 0; i < 4 && i < dlv_pc.size(); i++)
      check_eq("t2_order", dlv_pc[i], 32'h1C00_0000 + 32'(i * 4));

    // Two in flight, redirect; the stale beats are dropped and fetch restarts at once.
    do_reset();
    k_rsp_en = 1'b0;
    repeat (3) step();
    check_eq("t3_nacc", n_acc, 2);
    k_redir = 1'b1; k_redir_pc = 32'h1C00_0100; k_rsp_en = 1'b1;
    dlv_pc.delete();
    step();
    k_redir = 1'b0;
    step();
    check_eq("t3_req_after_redir", last_req, 1'b1);
    check_eq("t3_addr_after_redir", last_addr, 32'h1C00_0100);
    repeat (6) step();
    check_eq("t3_first_pc", dlv_pc.size() != 0 ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h1C00_0100);

    // Redirect in the same cycle as a live data_ok, with old entries buffered.
    do_reset();
    k_allow = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (n_acc >= 3 && dok_now()) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq("t4_dok_seen", seen, 1'b1);
    k_redir = 1'b1; k_redir_pc = 32'h1C00_0300;
    step();
    check_eq("t4_dok_in_redir", last_dok, 1'b1);
    check_eq("t4_buf_empty", fs_to_ds_valid, 1'b0);
    k_redir = 1'b0; k_allow = 1'b1;
    dlv_pc.delete();
    repeat (6) step();
    check_eq("t4_first_pc", dlv_pc.size() != 0 ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h1C00_0300);

    // Misaligned redirect target: one adef entry, then frozen until the next redirect.
    do_reset();
    k_redir = 1'b1; k_redir_pc = 32'h1C00_0102;
    step();
    k_redir = 1'b0;
    dlv_pc.delete();
    repeat (6) step();
    check_eq("t5_req_low", last_req, 1'b0);
    check_eq("t5_ndlv", dlv_pc.size(), 1);
    check_eq("t5_adef_pc", dlv_pc.size() != 0 ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h1C00_0102);
    k_redir = 1'b1; k_redir_pc = 32'h1C00_0200;
    step();
    k_redir = 1'b0;
    step();
    check_eq("t5_resume_req", last_req, 1'b1);
    check_eq("t5_resume_addr", last_addr, 32'h1C00_0200);

    // fetch_stall with two requests in flight: responses still land, no new issue.
    do_reset();
    k_rsp_en = 1'b0;
    repeat (2) step();
    k_stall = 1'b1; k_rsp_en = 1'b1;
    dlv_pc.delete();
    repeat (5) step();
    check_eq("t6_ndlv", dlv_pc.size(), 2);
    k_stall = 1'b0;
    step();
    check_eq("t6_req", last_req, 1'b1);
    check_eq("t6_addr", last_addr, 32'h1C00_0008);

    // pc wrap-around, then randomised traffic.
    do_reset();
    k_redir = 1'b1; k_redir_pc = 32'hFFFF_FFF8;
    step();
    k_redir = 1'b0;
    acc_addr.delete();
    repeat (4) step();
    check_eq("t7_wrap", acc_addr.size() >= 3 ? acc_addr[2] : 32'hFFFF_FFFF, 32'h0000_0000);
    for (int i = 0; i < 400; i++) begin
      k_aok    = ($urandom_range(0, 3) != 0);
      k_rsp_en = ($urandom_range(0, 2) != 0);
      k_allow  = ($urandom_range(0, 9) < 7);
      k_stall  = ($urandom_range(0, 9) == 0);
      k_redir  = ($urandom_range(0, 24) == 0);
      k_redir_pc = 32'h1C00_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 7) == 0) k_redir_pc = k_redir_pc | 32'h2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
